// File: rtl/pc_src_ctrl.sv
// pc_src_ctrl: PC-source/PC-write sequencer for branches, jumps and exceptions; define PCSRC_DIV0_EXC_EN to enable the divide-by-zero exception
module pc_src_ctrl #(
  parameter int         MEM_WAIT    = 1,
  parameter logic [7:0] VEC_INVALID = 8'd253,
  parameter logic [7:0] VEC_OVF     = 8'd254,
  parameter logic [7:0] VEC_DIV0    = 8'd255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] op_class,
  input  logic       alu_zero,
  input  logic       alu_gt,
  input  logic       exc_invalid,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic [2:0] pcsrc_sel,
  output logic       pc_write,
  output logic       epc_write,
  output logic       mem_read,
  output logic [7:0] exc_vec_addr,
  output logic [1:0] exc_code,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, EVAL, EXC_WAIT, EXC_LOAD, DONE} state_t;
`ifdef PCSRC_DIV0_EXC_EN
  localparam bit DIV0_EN = 1'b1;
`else
  localparam bit DIV0_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, sel_q, sel_d, tgt;
  logic [3:0] cls_q, cls_d;
  logic [1:0] code_q, code_d;
  logic [7:0] vec_q, vec_d;
  logic zero_q, zero_d, gt_q, gt_d, take;
  logic pw_q, pw_d, epc_q, epc_d, mr_q, mr_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cls_d = cls_q;
    zero_d = zero_q;
    gt_d = gt_q;
    code_d = code_q;
    vec_d = vec_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = EVAL;
        cls_d = op_class;
        zero_d = alu_zero;
        gt_d = alu_gt;
        code_d = exc_invalid ? 2'd1 : exc_ovf ? 2'd2 : (DIV0_EN && exc_div0) ? 2'd3 : 2'd0;
        vec_d = exc_invalid ? VEC_INVALID : exc_ovf ? VEC_OVF : (DIV0_EN && exc_div0) ? VEC_DIV0 : 8'd0;
      end
      EVAL: begin
        state_d = (code_q != 2'd0) ? EXC_WAIT : DONE;
        cnt_d = 3'(MEM_WAIT);
      end
      EXC_WAIT: begin
        state_d = (cnt_q == 3'd1) ? EXC_LOAD : EXC_WAIT;
        cnt_d = cnt_q - 3'd1;
      end
      EXC_LOAD: state_d = DONE;
      default: state_d = IDLE;
    endcase
    // outputs are decoded from the state being entered so they appear registered with it
    tgt = (cls_d inside {4'd1, 4'd2, 4'd3, 4'd4}) ? 3'd1 : (cls_d inside {4'd5, 4'd6}) ? 3'd2 : (cls_d == 4'd8) ? 3'd3 : 3'd0;
    take = (cls_d == 4'd1) ? zero_d : (cls_d == 4'd2) ? !zero_d : (cls_d == 4'd3) ? !gt_d :
           (cls_d == 4'd4) ? gt_d : (cls_d inside {4'd5, 4'd6, 4'd7, 4'd8});
    pw_d = (state_d == EVAL && code_d == 2'd0 && take) || state_d == EXC_LOAD;
    epc_d = state_d == EVAL && code_d != 2'd0;
    mr_d = epc_d || state_d == EXC_WAIT;
    sel_d = (state_d == EXC_WAIT || state_d == EXC_LOAD) ? 3'd4 : pw_d ? tgt : 3'd0;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cls_q <= '0;
      zero_q <= 1'b0;
      gt_q <= 1'b0;
      code_q <= '0;
      vec_q <= '0;
      sel_q <= '0;
      pw_q <= 1'b0;
      epc_q <= 1'b0;
      mr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cls_q <= cls_d;
      zero_q <= zero_d;
      gt_q <= gt_d;
      code_q <= code_d;
      vec_q <= vec_d;
      sel_q <= sel_d;
      pw_q <= pw_d;
      epc_q <= epc_d;
      mr_q <= mr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign pcsrc_sel = sel_q;
  assign pc_write = pw_q;
  assign epc_write = epc_q;
  assign mem_read = mr_q;
  assign exc_vec_addr = vec_q;
  assign exc_code = code_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_pc_src_ctrl.sv
// tb_pc_src_ctrl: directed self-checking bench for pc_src_ctrl (MEM_WAIT = 1)
module tb_pc_src_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [3:0] op_class = '0;
  logic alu_zero = 1'b0, alu_gt = 1'b0, exc_invalid = 1'b0, exc_ovf = 1'b0, exc_div0 = 1'b0;
  logic [2:0] pcsrc_sel;
  logic pc_write, epc_write, mem_read, busy, done;
  logic [7:0] exc_vec_addr;
  logic [1:0] exc_code;
  int n_cmp = 0, n_err = 0;
  pc_src_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_class(op_class),
    .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_invalid(exc_invalid), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .pcsrc_sel(pcsrc_sel), .pc_write(pc_write), .epc_write(epc_write),
    .mem_read(mem_read), .exc_vec_addr(exc_vec_addr), .exc_code(exc_code), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task issue(input logic [3:0] c, input logic z, input logic g, input logic inv, input logic ovf, input logic d0);
    start = 1'b1; op_class = c; alu_zero = z; alu_gt = g;
    exc_invalid = inv; exc_ovf = ovf; exc_div0 = d0;
    tick;
    start = 1'b0; exc_invalid = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
  endtask
  task test_reset;
    reset_n = 1'b0;
    tick; tick;
    n_cmp++;
    if ({pcsrc_sel, pc_write, epc_write, mem_read, exc_vec_addr, exc_code, busy, done} !== 18'd0) begin
      n_err++; $display("FAIL reset_outputs got %h exp 0", {pcsrc_sel, pc_write, epc_write, mem_read, exc_vec_addr, exc_code, busy, done});
    end
    reset_n = 1'b1;
    tick;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask
  task test_jump;
    issue(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({pc_write, pcsrc_sel, busy, done} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL j_cycle1 got pw=%b sel=%0d busy=%b done=%b exp pw=1 sel=2 busy=1 done=0", pc_write, pcsrc_sel, busy, done);
    end
    tick;
    n_cmp++;
    if ({done, pc_write, pcsrc_sel} !== {1'b1, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL j_cycle2 got done=%b pw=%b sel=%0d exp done=1 pw=0 sel=0", done, pc_write, pcsrc_sel);
    end
    tick;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL j_idle got busy=%b done=%b exp 0 0", busy, done); end
  endtask
  task test_branches;
    // {op_class, zero, gt, expected pc_write, expected pcsrc_sel}
    logic [9:0] vec [13] = '{
      {4'd1, 1'b1, 1'b0, 1'b1, 3'd1}, {4'd2, 1'b1, 1'b0, 1'b0, 3'd0},
      {4'd1, 1'b0, 1'b0, 1'b0, 3'd0}, {4'd2, 1'b0, 1'b0, 1'b1, 3'd1},
      {4'd3, 1'b0, 1'b0, 1'b1, 3'd1}, {4'd3, 1'b0, 1'b1, 1'b0, 3'd0},
      {4'd4, 1'b0, 1'b1, 1'b1, 3'd1}, {4'd4, 1'b0, 1'b0, 1'b0, 3'd0},
      {4'd7, 1'b0, 1'b0, 1'b1, 3'd0}, {4'd8, 1'b0, 1'b0, 1'b1, 3'd3},
      {4'd0, 1'b1, 1'b1, 1'b0, 3'd0}, {4'd12, 1'b1, 1'b1, 1'b0, 3'd0},
      {4'd6, 1'b0, 1'b0, 1'b1, 3'd2}};
    for (int i = 0; i < 13; i++) begin
      issue(vec[i][9:6], vec[i][5], vec[i][4], 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({pc_write, pcsrc_sel, epc_write} !== {vec[i][3], vec[i][2:0], 1'b0}) begin
        n_err++; $display("FAIL branch_%0d cls=%0d got pw=%b sel=%0d epc=%b exp pw=%b sel=%0d epc=0",
                          i, vec[i][9:6], pc_write, pcsrc_sel, epc_write, vec[i][3], vec[i][2:0]);
      end
      tick;
      n_cmp++;
      if ({done, pc_write} !== 2'b10) begin n_err++; $display("FAIL branch_done_%0d got done=%b pw=%b exp 1 0", i, done, pc_write); end
      tick;
    end
  endtask
  task test_ovf;
    issue(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({epc_write, mem_read, pc_write, pcsrc_sel, exc_vec_addr, exc_code} !== {1'b1, 1'b1, 1'b0, 3'd0, 8'd254, 2'd2}) begin
      n_err++; $display("FAIL ovf_c1 got epc=%b mr=%b pw=%b sel=%0d vec=%0d code=%0d exp 1 1 0 0 254 2",
                        epc_write, mem_read, pc_write, pcsrc_sel, exc_vec_addr, exc_code);
    end
    tick;
    n_cmp++;
    if ({epc_write, mem_read, pc_write, pcsrc_sel} !== {1'b0, 1'b1, 1'b0, 3'd4}) begin
      n_err++; $display("FAIL ovf_c2 got epc=%b mr=%b pw=%b sel=%0d exp 0 1 0 4", epc_write, mem_read, pc_write, pcsrc_sel);
    end
    tick;
    n_cmp++;
    if ({pc_write, pcsrc_sel, mem_read, epc_write, exc_vec_addr} !== {1'b1, 3'd4, 1'b0, 1'b0, 8'd254}) begin
      n_err++; $display("FAIL ovf_c3 got pw=%b sel=%0d mr=%b epc=%b vec=%0d exp 1 4 0 0 254", pc_write, pcsrc_sel, mem_read, epc_write, exc_vec_addr);
    end
    tick;
    n_cmp++;
    if ({done, pc_write, pcsrc_sel, exc_vec_addr} !== {1'b1, 1'b0, 3'd0, 8'd254}) begin
      n_err++; $display("FAIL ovf_c4 got done=%b pw=%b sel=%0d vec=%0d exp 1 0 0 254", done, pc_write, pcsrc_sel, exc_vec_addr);
    end
    tick;
    n_cmp++;
    if ({busy, exc_code} !== {1'b0, 2'd2}) begin n_err++; $display("FAIL ovf_hold got busy=%b code=%0d exp 0 2", busy, exc_code); end
  endtask
  task test_priority;
    int epc_n = 0, both_n = 0;
    issue(4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({exc_code, exc_vec_addr} !== {2'd1, 8'd253}) begin
      n_err++; $display("FAIL prio got code=%0d vec=%0d exp 1 253", exc_code, exc_vec_addr);
    end
    for (int i = 0; i < 5; i++) begin
      epc_n += int'(epc_write);
      both_n += int'(epc_write && pc_write);
      tick;
    end
    n_cmp++;
    if (epc_n !== 1) begin n_err++; $display("FAIL prio_epc_count got %0d exp 1", epc_n); end
    n_cmp++;
    if (both_n !== 0) begin n_err++; $display("FAIL prio_pw_epc_overlap got %0d exp 0", both_n); end
  endtask
  task test_busy_abort;
    int pw_n = 0;
    issue(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    issue(4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({exc_code, pc_write, pcsrc_sel} !== {2'd2, 1'b1, 3'd4}) begin
      n_err++; $display("FAIL busy_ignore got code=%0d pw=%b sel=%0d exp 2 1 4", exc_code, pc_write, pcsrc_sel);
    end
    tick; tick;
    n_cmp++;
    if ({busy, exc_code} !== {1'b0, 2'd2}) begin n_err++; $display("FAIL busy_settle got busy=%b code=%0d exp 0 2", busy, exc_code); end
    issue(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, pc_write, mem_read} !== 3'b000) begin
      n_err++; $display("FAIL abort_now got busy=%b pw=%b mr=%b exp 0 0 0", busy, pc_write, mem_read);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) reset_n = 1'b1;
      pw_n += int'(pc_write || epc_write || busy);
      tick;
    end
    n_cmp++;
    if (pw_n !== 0) begin n_err++; $display("FAIL abort_quiet got %0d active cycles exp 0", pw_n); end
  endtask
  task test_div0;
`ifdef PCSRC_DIV0_EXC_EN
    issue(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({exc_code, exc_vec_addr, epc_write, pc_write} !== {2'd3, 8'd255, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL div0_on got code=%0d vec=%0d epc=%b pw=%b exp 3 255 1 0", exc_code, exc_vec_addr, epc_write, pc_write);
    end
    tick; tick; tick;
`else
    issue(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({pc_write, pcsrc_sel, exc_code, epc_write, mem_read} !== {1'b1, 3'd0, 2'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL div0_off got pw=%b sel=%0d code=%0d epc=%b mr=%b exp 1 0 0 0 0",
                        pc_write, pcsrc_sel, exc_code, epc_write, mem_read);
    end
    tick;
`endif
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL div0_done got %b exp 1", done); end
    tick;
  endtask
  initial begin
    test_reset;
    test_jump;
    test_branches;
    test_ovf;
    test_priority;
    test_busy_abort;
    test_div0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_src_ctrl.md
Name: pc_src_ctrl

Overview:
- Sequential control block that drives the PC-source select and PC write strobe of the multicycle datapath; it is the producing end of the 3-bit PC-source selector.
- Started once per instruction after decode.
- Resolves branches and jumps; for exceptions, runs an EPC save, an exception-vector memory read, then the PC load.
- Emits a one-cycle done pulse back to the main control FSM.

Parameters:
- MEM_WAIT, 1, memory read latency in cycles between mem_read and a valid vector byte on the datapath (legal 1..7).
- VEC_INVALID, 8'd253, memory byte address of the invalid-opcode vector.
- VEC_OVF, 8'd254, memory byte address of the overflow vector.
- VEC_DIV0, 8'd255, memory byte address of the divide-by-zero vector.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; the instruction's class and flags are valid this cycle.
- op_class  in  4  0 SEQ, 1 BEQ, 2 BNE, 3 BLE, 4 BGT, 5 J, 6 JAL, 7 JR, 8 RTE, 9-15 reserved.
- alu_zero  in  1  ALU zero flag.
- alu_gt  in  1  ALU greater-than flag.
- exc_invalid  in  1  invalid opcode detected.
- exc_ovf  in  1  arithmetic overflow.
- exc_div0  in  1  divide by zero.
- pcsrc_sel  out  3  PC-source encoding: 0 ALU result, 1 ALUOut (branch target), 2 jump target, 3 EPC, 4 memory vector byte.
- pc_write  out  1  PC load strobe.
- epc_write  out  1  EPC capture strobe.
- mem_read  out  1  memory read request for the exception vector.
- exc_vec_addr  out  8  vector byte address.
- exc_code  out  2  0 none, 1 invalid, 2 overflow, 3 div0; holds until next start.
- busy  out  1  high whenever the FSM state is not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; wait counter 0. Reset mid-sequence aborts; no further pc_write or epc_write.
- Outputs are registered, Moore-style: decoded from state plus values latched at start.
- FSM states: IDLE, EVAL, EXC_WAIT, EXC_LOAD, DONE.
- IDLE: on start, latch op_class, alu_zero, alu_gt and the exception inputs, then go to EVAL. start while busy is ignored.

EVAL, no exception latched:
- BEQ: pc_write = zero; sel 1.
- BNE: pc_write = !zero; sel 1.
- BLE: pc_write = !gt; sel 1.
- BGT: pc_write = gt; sel 1.
- J and JAL: pc_write = 1; sel 2.
- JR: pc_write = 1; sel 0.
- RTE: pc_write = 1; sel 3.
- SEQ and reserved: pc_write = 0; sel 0.
- Next state: DONE.

EVAL, exception latched:
- Priority: invalid > overflow > div0.
- Outputs: epc_write = 1, mem_read = 1, exc_vec_addr set, exc_code set; branch/jump evaluation is suppressed.
- Next state: EXC_WAIT, counter loaded with MEM_WAIT.
- exc_vec_addr stays stable from EVAL through DONE.

EXC_WAIT and EXC_LOAD:
- EXC_WAIT: mem_read held high; counter decrements; move to EXC_LOAD when the counter reaches 1.
- EXC_LOAD: sel 4, pc_write = 1, mem_read = 0; next state DONE.

DONE: done = 1, pc_write = 0, pcsrc_sel = 0; next state IDLE.

Latency, with start in cycle 0:
- Normal path: pc_write in cycle 1, done in cycle 2.
- Exception path: epc_write in cycle 1, pc_write in cycle 1+MEM_WAIT+1, done one cycle later.

Other rules:
- pc_write and epc_write are never high in the same cycle.
- pc_write is never high outside EVAL and EXC_LOAD.
- pcsrc_sel is 0 whenever pc_write is 0, except during EXC_WAIT, where it is 4.

Optional Feature:
- Macro: PCSRC_DIV0_EXC_EN.
- Defined: exc_div0 is latched and raises exc_code 3 with vector VEC_DIV0.
- Undefined: exc_div0 is ignored; the instruction resolves as if no exception occurred; exc_code never equals 3.

Test Plan:
- Reset values: hold reset_n=0 then release -> all outputs 0, busy 0. Pulse start with op_class 5 -> cycle 1 shows pc_write 1 and pcsrc_sel 2; cycle 2 shows done 1.
- BEQ/BNE, op_class 1 then 2, with alu_zero 1 -> BEQ gives pc_write 1, sel 1; BNE gives pc_write 0. Repeat with alu_zero 0 -> results invert.
- Overflow with MEM_WAIT 1: op_class 0 with exc_ovf 1 -> cycle 1: epc_write 1, mem_read 1, exc_vec_addr 254, exc_code 2; cycle 3: pc_write 1, sel 4; cycle 4: done.
- Priority: exc_invalid=1, exc_ovf=1, exc_div0=1 together -> exc_code 1, exc_vec_addr 253, single epc_write.
- Busy and reset abort: start during EXC_WAIT -> ignored, exc_code unchanged. Assert reset_n=0 in EXC_WAIT -> pc_write never pulses, busy drops immediately.
- Div-by-zero option: exc_div0 only with PCSRC_DIV0_EXC_EN defined -> vector 255, exc_code 3. Macro undefined with op_class 7 -> plain JR: pc_write 1, sel 0, exc_code 0.
